// File: rtl/cache_way_store.sv
// Storage back-end of the partitioned L1 cache: tag/metadata, line data and LRU age arrays.
// Optional macro CACHE_LRU_ORDER_EN adds the lru_order output (ways sorted from MRU to LRU).
module cache_way_store #(
   parameter int WAYS    = 4,
   parameter int WAY_W   = 2,
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 18,
   parameter int DOM_W   = 2,
   parameter int LINE_W  = 128
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [INDEX_W-1:0]                index,
   input  logic [WAY_W-1:0]                  way_index,
   input  logic                              tag_req_we,
   input  logic [TAG_W+DOM_W+1:0]            tag_write,
   output logic [WAYS*(TAG_W+DOM_W+2)-1:0]   tag_read,
   input  logic                              data_req_we,
   input  logic [LINE_W-1:0]                 data_write,
   output logic [WAYS*LINE_W-1:0]            data_read,
   input  logic                              lru_req_we,
   input  logic [WAYS*WAY_W-1:0]             lru_write,
   output logic [WAYS*WAY_W-1:0]             lru_read
`ifdef CACHE_LRU_ORDER_EN
   ,
   output logic [WAYS*WAY_W-1:0]             lru_order
`endif
);

   localparam int ENTRY_W  = TAG_W + DOM_W + 2;
   localparam int NUM_SETS = 2 ** INDEX_W;

   logic [ENTRY_W-1:0]    r_tagMem  [NUM_SETS][WAYS];
   logic [LINE_W-1:0]     r_dataMem [NUM_SETS][WAYS];
   logic [WAYS*WAY_W-1:0] r_lruMem  [NUM_SETS];

   // Tag and LRU arrays clear on reset; a reset cycle swallows any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_tagMem[s][w]                 <= '0;
               r_lruMem[s][w*WAY_W +: WAY_W]  <= WAY_W'(w);
            end
         end
      end else begin
         if (tag_req_we) begin
            r_tagMem[index][way_index] <= tag_write;
         end
         if (lru_req_we) begin
            r_lruMem[index] <= lru_write;
         end
      end
   end

   // Line data has no reset so it can map onto plain RAM, but still obeys reset priority.
   always_ff @(posedge clk) begin
      if (data_req_we && !rst) begin
         r_dataMem[index][way_index] <= data_write;
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : gRead
      assign tag_read[g*ENTRY_W +: ENTRY_W] = r_tagMem[index][g];
      assign data_read[g*LINE_W +: LINE_W]  = r_dataMem[index][g];
   end

   assign lru_read = r_lruMem[index];

`ifdef CACHE_LRU_ORDER_EN
   logic [WAYS*WAY_W-1:0] w_order;

   // Scanning ways from high to low lets the lowest-numbered way win an age tie.
   always_comb begin
      w_order = '0;
      for (int k = 0; k < WAYS; k++) begin
         w_order[k*WAY_W +: WAY_W] = WAY_W'(k);
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (lru_read[w*WAY_W +: WAY_W] == WAY_W'(k)) begin
               w_order[k*WAY_W +: WAY_W] = WAY_W'(w);
            end
         end
      end
   end

   assign lru_order = w_order;
`endif

endmodule

// File: tb/tb_cache_way_store.sv
// Self-checking bench for cache_way_store: directed scenarios followed by randomized traffic
// compared against a per-set/per-way reference model. Honours CACHE_LRU_ORDER_EN.
module tb_cache_way_store;

   localparam int WAYS     = 4;
   localparam int WAY_W    = 2;
   localparam int INDEX_W  = 10;
   localparam int TAG_W    = 18;
   localparam int DOM_W    = 2;
   localparam int LINE_W   = 128;
   localparam int ENTRY_W  = TAG_W + DOM_W + 2;
   localparam int NUM_SETS = 1 << INDEX_W;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [INDEX_W-1:0]          index;
   logic [WAY_W-1:0]            way_index;
   logic                        tag_req_we;
   logic [ENTRY_W-1:0]          tag_write;
   logic [WAYS*ENTRY_W-1:0]     tag_read;
   logic                        data_req_we;
   logic [LINE_W-1:0]           data_write;
   logic [WAYS*LINE_W-1:0]      data_read;
   logic                        lru_req_we;
   logic [WAYS*WAY_W-1:0]       lru_write;
   logic [WAYS*WAY_W-1:0]       lru_read;
`ifdef CACHE_LRU_ORDER_EN
   logic [WAYS*WAY_W-1:0]       lru_order;
`endif

   cache_way_store dut (
      .clk         (clk),
      .rst         (rst),
      .index       (index),
      .way_index   (way_index),
      .tag_req_we  (tag_req_we),
      .tag_write   (tag_write),
      .tag_read    (tag_read),
      .data_req_we (data_req_we),
      .data_write  (data_write),
      .data_read   (data_read),
      .lru_req_we  (lru_req_we),
      .lru_write   (lru_write),
      .lru_read    (lru_read)
`ifdef CACHE_LRU_ORDER_EN
      ,
      .lru_order   (lru_order)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: one entry per (set, way), with ages kept as plain integers.
   logic [ENTRY_W-1:0] mTag   [NUM_SETS][WAYS];
   int                 mAge   [NUM_SETS][WAYS];
   logic [LINE_W-1:0]  mData  [NUM_SETS][WAYS];
   bit                 mKnown [NUM_SETS][WAYS];

   int compareCount  = 0;
   int mismatchCount = 0;

   task automatic checkOutput(input string name, input logic [511:0] observed,
                              input logic [511:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int s = 0; s < NUM_SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            mTag[s][w] = '0;
            mAge[s][w] = w;
         end
      end
   endtask

   // Compare every output for the currently driven index against the model.
   task automatic checkSet(input string phase);
      int s;
      logic [WAYS*ENTRY_W-1:0] expTag;
      logic [WAYS*WAY_W-1:0]   expLru;
      s = int'(index);
      for (int w = 0; w < WAYS; w++) begin
         expTag[w*ENTRY_W +: ENTRY_W] = mTag[s][w];
         expLru[w*WAY_W +: WAY_W]     = WAY_W'(mAge[s][w]);
      end
      checkOutput({phase, " tag_read"}, tag_read, expTag);
      checkOutput({phase, " lru_read"}, lru_read, expLru);
      for (int w = 0; w < WAYS; w++) begin
         if (mKnown[s][w]) begin
            checkOutput($sformatf("%s data_read way%0d", phase, w),
                        data_read[w*LINE_W +: LINE_W], mData[s][w]);
         end
      end
`ifdef CACHE_LRU_ORDER_EN
      begin
         logic [WAYS*WAY_W-1:0] expOrder;
         for (int k = 0; k < WAYS; k++) begin
            bit found = 0;
            int who   = k;
            for (int w = 0; w < WAYS; w++) begin
               if (!found && mAge[s][w] == k) begin
                  who   = w;
                  found = 1;
               end
            end
            expOrder[k*WAY_W +: WAY_W] = WAY_W'(who);
         end
         checkOutput({phase, " lru_order"}, lru_order, expOrder);
      end
`endif
   endtask

   // One clock of stimulus: old contents are checked before the edge, new contents after it.
   task automatic applyStimulus(input int idx, input int way, input bit tWe,
                                input logic [ENTRY_W-1:0] tVal, input bit dWe,
                                input logic [LINE_W-1:0] dVal, input bit lWe,
                                input logic [WAYS*WAY_W-1:0] lVal, input bit r);
      @(negedge clk);
      index       = INDEX_W'(idx);
      way_index   = WAY_W'(way);
      tag_req_we  = tWe;
      tag_write   = tVal;
      data_req_we = dWe;
      data_write  = dVal;
      lru_req_we  = lWe;
      lru_write   = lVal;
      rst         = r;
      #1 checkSet("pre-edge");
      @(posedge clk);
      if (r) begin
         modelReset();
      end else begin
         if (tWe) mTag[idx][way] = tVal;
         if (dWe) begin
            mData[idx][way]  = dVal;
            mKnown[idx][way] = 1;
         end
         if (lWe) begin
            for (int w = 0; w < WAYS; w++) mAge[idx][w] = int'(lVal[w*WAY_W +: WAY_W]);
         end
      end
      #1 checkSet("post-edge");
   endtask

   task automatic idleRead(input int idx);
      applyStimulus(idx, 0, 0, '0, 0, '0, 0, '0, 0);
   endtask

   localparam logic [ENTRY_W-1:0] PLAN_TAG  = {1'b1, 1'b0, 18'h2A5F1, 2'd1};
   localparam logic [LINE_W-1:0]  PLAN_DATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   initial begin
      rst = 1'b1; index = '0; way_index = '0;
      tag_req_we = 0; tag_write = '0; data_req_we = 0; data_write = '0;
      lru_req_we = 0; lru_write = '0;
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < WAYS; w++) mKnown[s][w] = 0;
      repeat (2) @(posedge clk);
      modelReset();
      @(negedge clk);
      rst   = 1'b0;
      index = 10'd5;
      #1;
      checkOutput("reset tag_read set5", tag_read, '0);
      checkOutput("reset lru_read set5", lru_read, 8'hE4);
      checkSet("reset");

      // Single tag write; neighbours in the set and the next set stay clear.
      applyStimulus(5, 2, 1, PLAN_TAG, 0, '0, 0, '0, 0);
      checkOutput("tag way2 value", tag_read[2*ENTRY_W +: ENTRY_W], PLAN_TAG);
      idleRead(6);
      checkOutput("set6 tag_read zero", tag_read, '0);

      // Data write over a previously known line exposes the old value during the write.
      applyStimulus(5, 3, 0, '0, 1, {4{32'h11112222}}, 0, '0, 0);
      applyStimulus(5, 0, 0, '0, 1, {4{32'h0BAD0BAD}}, 0, '0, 0);
      applyStimulus(5, 3, 0, '0, 1, PLAN_DATA, 0, '0, 0);
      checkOutput("data way3 value", data_read[3*LINE_W +: LINE_W], PLAN_DATA);
      checkOutput("data way0 kept", data_read[0 +: LINE_W], {4{32'h0BAD0BAD}});

      // LRU write ages way0..3 = 2,0,3,1.
      applyStimulus(7, 0, 0, '0, 0, '0, 1, 8'h72, 0);
      checkOutput("lru set7 value", lru_read, 8'h72);
`ifdef CACHE_LRU_ORDER_EN
      checkOutput("lru_order set7", lru_order, 8'h8D);
`endif

      // All three enables together, then the same cycle with reset taking priority.
      applyStimulus(9, 1, 1, {1'b1, 1'b1, 18'h3C0DE, 2'd2}, 1, {4{32'hA5A5F00F}}, 1, 8'h1B, 0);
      checkOutput("simul tag way1", tag_read[1*ENTRY_W +: ENTRY_W], {1'b1, 1'b1, 18'h3C0DE, 2'd2});
      checkOutput("simul lru", lru_read, 8'h1B);
      applyStimulus(9, 1, 1, {1'b1, 1'b1, 18'h3C0DE, 2'd2}, 1, {4{32'hA5A5F00F}}, 1, 8'h1B, 1);
      checkOutput("reset-win tag way1", tag_read[1*ENTRY_W +: ENTRY_W], '0);
      checkOutput("reset-win lru", lru_read, 8'hE4);

      // Back-to-back tag writes at the extremes of the index range.
      applyStimulus(0, 0, 1, {1'b1, 1'b0, 18'h00001, 2'd3}, 0, '0, 0, '0, 0);
      applyStimulus(1023, 3, 1, {1'b1, 1'b1, 18'h3FFFF, 2'd0}, 0, '0, 0, '0, 0);
      idleRead(0);
      checkOutput("b2b set0 way0", tag_read[0 +: ENTRY_W], {1'b1, 1'b0, 18'h00001, 2'd3});
      idleRead(1023);
      checkOutput("b2b set1023 way3", tag_read[3*ENTRY_W +: ENTRY_W], {1'b1, 1'b1, 18'h3FFFF, 2'd0});

      // Randomized traffic concentrated on a few sets so writes collide and get read back.
      for (int n = 0; n < 400; n++) begin
         int idx;
         idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_SETS - 1))
                                           : int'($urandom_range(0, 7));
         applyStimulus(idx, int'($urandom_range(0, WAYS - 1)),
                       bit'($urandom_range(0, 1)), ENTRY_W'($urandom),
                       bit'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                       bit'($urandom_range(0, 2) == 0), 8'($urandom),
                       bit'($urandom_range(0, 39) == 0));
      end

      @(negedge clk);
      tag_req_we = 0; data_req_we = 0; lru_req_we = 0; rst = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
